pc_sequencer: RTL and testbench

Fetch-side controller that owns the architectural PC and sequences the branch unit's resolution against instruction fetch. Sits between the execute-stage branch resolver (which supplies taken/target) and instruction memory. Issues sequential fetch requests over a valid/ready handshake, predicts not-taken, and redirects plus flushes on a resolved taken branch. Faults on a misaligned taken target.

---
 rtl/pc_sequencer_if.sv | 45 ++++
 rtl/pc_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
//
// Groups the two buses that the PC sequencer sits between:
//   - the instruction-fetch request handshake toward instruction memory
//     (iaddr/ivalid out of the sequencer, iready back in), and
//   - the resolved-branch bus from the execute-stage branch resolver
//     (br_valid/br_taken/br_target/br_pc into the sequencer).
//
// Modports:
//   master : the sequencer side (drives fetch request, receives branch info)
//   slave  : the environment side (memory + branch resolver)
// ---------------------------------------------------------------------------
interface pc_sequencer_if;
    // Fetch request handshake
    logic [31:0] iaddr;
    logic        ivalid;
    logic        iready;

    // Resolved branch from execute
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] br_pc;

    modport master (
        output iaddr,
        output ivalid,
        input  iready,
        input  br_valid,
        input  br_taken,
        input  br_target,
        input  br_pc
    );

    modport slave (
        input  iaddr,
        input  ivalid,
        output iready,
        output br_valid,
        output br_taken,
        output br_target,
        output br_pc
    );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Fetch-side controller owning the architectural PC. Issues sequential fetch
// requests (predict not-taken), redirects and flushes on a resolved taken
// branch, and halts with a sticky fault on a misaligned taken target.
//
// Parameters:
//   RESET_PC : PC value loaded on reset
//   CNT_W    : width of the performance counters
//
// Ports:
//   clk          core clock
//   rst          asynchronous, active-high reset
//   bus          pc_sequencer_if.master: iaddr/ivalid/iready fetch handshake
//                and br_valid/br_taken/br_target/br_pc branch resolution
//   stall_i      backend cannot take more instructions
//   flush_o      one-cycle pulse: drop all fetched, not-yet-executed instrs
//   misalign_o   sticky fault: taken target not word-aligned
//   pc_o         current PC register (faulting br_pc after misalign)
//   br_cnt_o     resolved-branch count (saturating)
//   taken_cnt_o  redirect count (saturating)
//
// Build option:
//   PERF_CNT_EN  when defined, the saturating branch/redirect counters are
//                built; otherwise br_cnt_o and taken_cnt_o are tied to zero.
//
// All outputs come from registers or from the state register alone, so there
// is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    pc_sequencer_if.master      bus,
    input  logic                stall_i,
    output logic                flush_o,
    output logic                misalign_o,
    output logic [31:0]         pc_o,
    output logic [CNT_W-1:0]    br_cnt_o,
    output logic [CNT_W-1:0]    taken_cnt_o
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        RUN   = 3'd1,
        STALL = 3'd2,
        REDIR = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        misalign_q, misalign_d;

    logic        active;
    logic        br_take;
    logic        tgt_aligned;
    logic        redirect;
    logic        bad_target;
    logic        handshake;

    // -----------------------------------------------------------------------
    // Event decode
    // -----------------------------------------------------------------------
    always_comb begin
        active      = (state_q != HALT);
        br_take     = bus.br_valid && bus.br_taken && active;
        tgt_aligned = (bus.br_target[1:0] == 2'b00);
        redirect    = br_take && tgt_aligned;
        bad_target  = br_take && !tgt_aligned;
        // ivalid is exactly (state_q == RUN), so this is ivalid && iready.
        handshake   = (state_q == RUN) && bus.iready;
    end

    // -----------------------------------------------------------------------
    // Next-state / next-PC
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                // Without a handshake the request (and stall) is simply held.
                if (handshake) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = stall_i ? STALL : RUN;
                end
            end
            STALL: begin
                if (!stall_i) begin
                    state_d = RUN;
                end
            end
            REDIR: begin
                state_d = RUN;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // Branch resolution overrides everything above, including a
        // handshake PC increment; br_take is already false in HALT.
        if (bad_target) begin
            pc_d       = bus.br_pc;
            misalign_d = 1'b1;
            state_d    = HALT;
        end else if (redirect) begin
            pc_d    = bus.br_target;
            state_d = REDIR;
        end

        // Flush is asserted for the REDIR cycle and for the first HALT cycle.
        flush_d = (state_d == REDIR) || ((state_d == HALT) && (state_q != HALT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.iaddr  = pc_q;
    assign bus.ivalid = (state_q == RUN);
    assign flush_o    = flush_q;
    assign misalign_o = misalign_q;
    assign pc_o       = pc_q;

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    always_comb begin
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (bus.br_valid && active) begin
            br_cnt_d = sat_inc(br_cnt_q);
        end
        if (redirect) begin
            taken_cnt_d = sat_inc(taken_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign br_cnt_o    = br_cnt_q;
    assign taken_cnt_o = taken_cnt_q;
`else
    assign br_cnt_o    = '0;
    assign taken_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer. A behavioural model tracks what the fetch
// outputs must be from the externally visible rules (fetching / waiting on
// stall / flushing / halted) and is compared against the DUT every cycle;
// directed steps additionally pin hand-computed literal values.
// Counters use CNT_W=4 so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          CW     = 4;
    localparam int unsigned CMAX   = 15;
`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall;
    logic          flush;
    logic          misalign;
    logic [31:0]   pc;
    logic [CW-1:0] br_cnt;
    logic [CW-1:0] taken_cnt;

    int total = 0;
    int bad   = 0;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC (RST_PC),
        .CNT_W    (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .stall_i     (stall),
        .flush_o     (flush),
        .misalign_o  (misalign),
        .pc_o        (pc),
        .br_cnt_o    (br_cnt),
        .taken_cnt_o (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: m_* hold what the outputs must show in the cycle
    // following each edge.
    // -----------------------------------------------------------------------
    logic [31:0] m_pc;
    bit          m_iv, m_fl, m_mis, m_boot, m_halt, m_hs;
    int unsigned m_brc, m_tkc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc   = RST_PC;
            m_iv   = 0;
            m_fl   = 0;
            m_mis  = 0;
            m_boot = 1;
            m_halt = 0;
            m_brc  = 0;
            m_tkc  = 0;
        end else if (m_halt) begin
            m_fl = 0;
        end else begin
            m_hs = m_iv && bus.iready;
            if (bus.br_valid && m_brc < CMAX) m_brc++;
            if (bus.br_valid && bus.br_taken && bus.br_target[1:0] != 2'b00) begin
                m_pc   = bus.br_pc;
                m_halt = 1;
                m_mis  = 1;
                m_fl   = 1;
                m_iv   = 0;
            end else if (bus.br_valid && bus.br_taken) begin
                m_pc = bus.br_target;
                m_fl = 1;
                m_iv = 0;
                if (m_tkc < CMAX) m_tkc++;
            end else begin
                if (m_hs) m_pc = m_pc + 32'd4;
                if (m_boot || m_fl) m_iv = 1;        // fetching resumes after boot/flush
                else if (m_iv)      m_iv = !(m_hs && stall);
                else                m_iv = !stall;   // waiting for stall to drop
                m_fl = 0;
            end
            m_boot = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cyc_iaddr",     bus.iaddr,       m_pc);
        chk("cyc_pc",        pc,              m_pc);
        chk("cyc_ivalid",    32'(bus.ivalid), 32'(m_iv));
        chk("cyc_flush",     32'(flush),      32'(m_fl));
        chk("cyc_misalign",  32'(misalign),   32'(m_mis));
        chk("cyc_br_cnt",    32'(br_cnt),     PERF ? m_brc : 32'd0);
        chk("cyc_taken_cnt", 32'(taken_cnt),  PERF ? m_tkc : 32'd0);
    end

    // -----------------------------------------------------------------------
    // Directed stimulus (inputs change on the falling edge)
    // -----------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_br(input logic v, input logic t, input logic [31:0] tgt, input logic [31:0] bpc);
        bus.br_valid  = v;
        bus.br_taken  = t;
        bus.br_target = tgt;
        bus.br_pc     = bpc;
    endtask

    initial begin
        bus.iready = 1'b1;
        stall      = 1'b0;
        set_br(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state, then release.
        step(2);
        rst = 1'b0;
        #1;
        chk("rst_ivalid",   32'(bus.ivalid), 32'd0);
        chk("rst_pc",       pc,              32'h100);
        chk("rst_flush",    32'(flush),      32'd0);
        chk("rst_misalign", 32'(misalign),   32'd0);
        chk("rst_br_cnt",   32'(br_cnt),     32'd0);

        // Sequential fetch from RESET_PC.
        step(1);
        chk("boot_ivalid", 32'(bus.ivalid), 32'd1);
        chk("seq0",        bus.iaddr,       32'h100);
        step(1);
        chk("seq1",        bus.iaddr,       32'h104);
        step(1);
        chk("seq2",        bus.iaddr,       32'h108);

        // Memory not ready: request held.
        bus.iready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("hold_ivalid", 32'(bus.ivalid), 32'd1);
            chk("hold_iaddr",  bus.iaddr,       32'h108);
        end
        bus.iready = 1'b1;
        step(1);
        chk("hold_release", bus.iaddr, 32'h10C);

        // Aligned taken branch to 0x400.
        set_br(1'b1, 1'b1, 32'h400, 32'h0F0);
        step(1);
        set_br(1'b0, 1'b0, 32'h0, 32'h0);
        chk("redir_flush",  32'(flush),      32'd1);
        chk("redir_ivalid", 32'(bus.ivalid), 32'd0);
        chk("redir_brcnt",  32'(br_cnt),     PERF ? 32'd1 : 32'd0);
        chk("redir_tkcnt",  32'(taken_cnt),  PERF ? 32'd1 : 32'd0);
        step(1);
        chk("redir_unflush", 32'(flush),      32'd0);
        chk("redir_iv",      32'(bus.ivalid), 32'd1);
        chk("redir_iaddr",   bus.iaddr,       32'h400);

        // Redirect to 0x200, then handshake under stall.
        set_br(1'b1, 1'b1, 32'h200, 32'h404);
        step(1);
        set_br(1'b0, 1'b0, 32'h0, 32'h0);
        step(1);
        chk("st_iaddr", bus.iaddr, 32'h200);
        stall = 1'b1;
        step(1);
        chk("st_pc",  pc,              32'h204);
        chk("st_iv0", 32'(bus.ivalid), 32'd0);
        step(1);
        chk("st_iv1", 32'(bus.ivalid), 32'd0);
        stall = 1'b0;
        step(1);
        chk("st_resume_iv", 32'(bus.ivalid), 32'd1);
        chk("st_resume_pc", bus.iaddr,       32'h204);
        step(1);
        chk("st_next", bus.iaddr, 32'h208);

        // PC wrap at the top of the address space.
        set_br(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h208);
        step(1);
        set_br(1'b0, 1'b0, 32'h0, 32'h0);
        step(1);
        chk("wrap_top",  bus.iaddr, 32'hFFFF_FFFC);
        step(1);
        chk("wrap_zero", bus.iaddr, 32'h0000_0000);

        // Not-taken branch has no PC effect.
        set_br(1'b1, 1'b0, 32'h800, 32'h0);
        step(1);
        set_br(1'b0, 1'b0, 32'h0, 32'h0);
        chk("nt_iaddr", bus.iaddr,   32'h4);
        chk("nt_flush", 32'(flush),  32'd0);
        chk("nt_brcnt", 32'(br_cnt), PERF ? 32'd4 : 32'd0);

        // Misaligned taken target: fault and halt.
        set_br(1'b1, 1'b1, 32'h402, 32'h3F0);
        step(1);
        set_br(1'b0, 1'b0, 32'h0, 32'h0);
        chk("mis_flag",  32'(misalign),   32'd1);
        chk("mis_pc",    pc,              32'h3F0);
        chk("mis_flush", 32'(flush),      32'd1);
        chk("mis_iv",    32'(bus.ivalid), 32'd0);
        step(1);
        chk("mis_flush_drop", 32'(flush), 32'd0);
        set_br(1'b1, 1'b1, 32'h500, 32'h3F4);
        step(2);
        set_br(1'b0, 1'b0, 32'h0, 32'h0);
        chk("halt_pc",    pc,              32'h3F0);
        chk("halt_iv",    32'(bus.ivalid), 32'd0);
        chk("halt_flush", 32'(flush),      32'd0);
        chk("halt_mis",   32'(misalign),   32'd1);
        chk("halt_brcnt", 32'(br_cnt),     PERF ? 32'd5 : 32'd0);
        chk("halt_tkcnt", 32'(taken_cnt),  PERF ? 32'd3 : 32'd0);

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pc",  pc,              32'h100);
        chk("arst_mis", 32'(misalign),   32'd0);
        chk("arst_iv",  32'(bus.ivalid), 32'd0);
        step(1);
        rst = 1'b0;

        // Counter saturation with a stream of not-taken branches.
        set_br(1'b1, 1'b0, 32'h0, 32'h0);
        step(20);
        set_br(1'b0, 1'b0, 32'h0, 32'h0);
        step(1);
        chk("sat_brcnt", 32'(br_cnt),    PERF ? 32'd15 : 32'd0);
        chk("sat_tkcnt", 32'(taken_cnt), 32'd0);

        // Redirect wins over a simultaneous stall.
        stall = 1'b1;
        set_br(1'b1, 1'b1, 32'h600, 32'h0);
        step(1);
        set_br(1'b0, 1'b0, 32'h0, 32'h0);
        chk("rs_flush", 32'(flush), 32'd1);
        step(1);
        chk("rs_iv",    32'(bus.ivalid), 32'd1);
        chk("rs_iaddr", bus.iaddr,       32'h600);
        step(1);
        chk("rs_stalled", 32'(bus.ivalid), 32'd0);
        stall = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
